// File: rtl/myproject_mul_pkg.sv
// myproject_mul_pkg: shared constants, control struct and parameter helpers for the pipelined multiplier
package myproject_mul_pkg;
  localparam int MUL_MODE_MUL = 0;
  localparam int MUL_MODE_MAC = 1;
  localparam int RND_TRUNC = 0;
  localparam int RND_HALF_UP = 1;
  localparam int SAT_WRAP = 0;
  localparam int SAT_CLAMP = 1;
  typedef struct packed {
    logic valid;
    logic clr;
    logic last;
  } mul_ctl_t;
  function automatic int prod_width(int w0, int w1);
    return w0 + w1;
  endfunction
  function automatic bit params_ok(int id, int mode, int rnd, int sat, int num_stage, int acc_width, int pw, int shift);
    return id >= 0 && (mode == MUL_MODE_MUL || mode == MUL_MODE_MAC)
      && (rnd == RND_TRUNC || rnd == RND_HALF_UP) && (sat == SAT_WRAP || sat == SAT_CLAMP)
      && num_stage >= 1 && acc_width >= pw && shift >= 0 && shift < acc_width;
  endfunction
endpackage

// File: rtl/myproject_mul_pipe_if.sv
// myproject_mul_pipe_if: operand and result bundle of myproject_mul_pipe
interface myproject_mul_pipe_if #(
  parameter int W0 = 16,
  parameter int W1 = 21,
  parameter int WO = 37
);
  logic ce, in_valid, acc_clr, acc_last, out_valid, ovf;
  logic [W0-1:0] din0;
  logic [W1-1:0] din1;
  logic [WO-1:0] dout;
  modport master (output ce, in_valid, din0, din1, acc_clr, acc_last, input out_valid, dout, ovf);
  modport slave (input ce, in_valid, din0, din1, acc_clr, acc_last, output out_valid, dout, ovf);
endinterface

// File: rtl/myproject_mul_quant.sv
// myproject_mul_quant: combinational arithmetic shift, optional half-up rounding, wrap or saturate with overflow flag
module myproject_mul_quant
  import myproject_mul_pkg::*;
#(
  parameter int XW = 48,
  parameter int OW = 37,
  parameter int SIGNED = 1,
  parameter int SHIFT = 0,
  parameter int RND = RND_TRUNC,
  parameter int SAT = SAT_WRAP
) (
  input  logic [XW-1:0] x,
  output logic [OW-1:0] y,
  output logic          ovf
);
  localparam int MW = (XW + 2 > OW + 1) ? XW + 2 : OW + 1;
  localparam logic [MW-1:0] HALF = (RND == RND_HALF_UP && SHIFT > 0) ? MW'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
  logic sgn;
  logic signed [MW-1:0] e, v;
  always_comb begin
    sgn = SIGNED != 0 && x[XW-1];
    e = {{(MW-XW){sgn}}, x};
    v = $signed(e + HALF) >>> SHIFT;
    ovf = SIGNED != 0 ? !(&v[MW-1:OW-1] || !(|v[MW-1:OW-1])) : |v[MW-1:OW];
    y = (ovf && SAT == SAT_CLAMP) ? (SIGNED != 0 ? {v[MW-1], {(OW-1){~v[MW-1]}}} : {OW{1'b1}}) : v[OW-1:0];
  end
endmodule

// File: rtl/myproject_mul_pipe.sv
// myproject_mul_pipe: pipelined mixed-sign multiplier with optional accumulate and fixed-point output quantiser
module myproject_mul_pipe
  import myproject_mul_pkg::*;
#(
  parameter int ID = 1,
  parameter int NUM_STAGE = 2,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 21,
  parameter int din0_SIGNED = 1,
  parameter int din1_SIGNED = 0,
  parameter int MODE = MUL_MODE_MUL,
  parameter int ACC_WIDTH = 48,
  parameter int SHIFT = 0,
  parameter int RND = RND_TRUNC,
  parameter int SAT = SAT_WRAP,
  parameter int dout_WIDTH = 37
) (
  input logic ap_clk,
  input logic ap_rst,
  myproject_mul_pipe_if.slave bus
);
  localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);
  localparam bit PSIGNED = din0_SIGNED != 0 || din1_SIGNED != 0;
  localparam bit MAC = MODE == MUL_MODE_MAC;
  localparam int D = NUM_STAGE - 1 + (MAC ? 1 : 0);
  if (!params_ok(ID, MODE, RND, SAT, NUM_STAGE, ACC_WIDTH, PW, SHIFT)) begin : g_bad
    $error("myproject_mul_pipe: illegal parameter set");
  end
  logic signed [din0_WIDTH:0] a;
  logic signed [din1_WIDTH:0] b;
  logic [PW-1:0] p0, px;
  mul_ctl_t c0, cx;
  logic [ACC_WIDTH-1:0] x, acc, acc_next, qin;
  logic [dout_WIDTH-1:0] q;
  logic qovf, fire;
  always_comb begin
    a = {din0_SIGNED != 0 && bus.din0[din0_WIDTH-1], bus.din0};
    b = {din1_SIGNED != 0 && bus.din1[din1_WIDTH-1], bus.din1};
    p0 = PW'(a) * PW'(b);
    c0 = '{valid: bus.in_valid, clr: bus.acc_clr, last: bus.acc_last};
    x = PSIGNED ? ACC_WIDTH'($signed(px)) : ACC_WIDTH'(px);
    acc_next = (cx.clr ? '0 : acc) + x;
    qin = MAC ? acc_next : x;
    fire = cx.valid && (!MAC || cx.last);
  end
  if (D == 0) begin : g_direct
    assign px = p0;
    assign cx = c0;
  end else begin : g_pipe
    logic [PW-1:0] pp [1:D];
    mul_ctl_t pc [1:D];
    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        for (int i = 1; i <= D; i++) pc[i] <= '0;
      end else if (bus.ce) begin
        pp[1] <= p0;
        pc[1] <= c0;
        for (int i = 2; i <= D; i++) begin
          pp[i] <= pp[i-1];
          pc[i] <= pc[i-1];
        end
      end
    end
    assign px = pp[D];
    assign cx = pc[D];
  end
  myproject_mul_quant #(
    .XW(ACC_WIDTH), .OW(dout_WIDTH), .SIGNED(PSIGNED ? 1 : 0), .SHIFT(SHIFT), .RND(RND), .SAT(SAT)
  ) u_quant (
    .x(qin), .y(q), .ovf(qovf)
  );
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc <= '0;
      bus.out_valid <= 1'b0;
      bus.dout <= '0;
      bus.ovf <= 1'b0;
    end else if (bus.ce) begin
      if (MAC && cx.valid) acc <= acc_next;
      bus.out_valid <= fire;
      if (fire) begin
        bus.dout <= q;
        bus.ovf <= qovf;
      end
    end
  end
endmodule

// File: tb/tb_myproject_mul_pipe.sv
// tb_myproject_mul_pipe: directed checks of multiply latency, quantiser, accumulate, stall and reset
module tb_myproject_mul_pipe;
  import myproject_mul_pkg::*;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic ce = 1'b1, iv = 1'b0, clr = 1'b0, last = 1'b0;
  logic [15:0] d0 = '0;
  logic [20:0] d1 = '0;
  int total = 0, bad = 0;
  always #5 ap_clk = ~ap_clk;
  myproject_mul_pipe_if #(.W0(16), .W1(21), .WO(37)) i0 (), i1 (), i2 (), i5 ();
  myproject_mul_pipe_if #(.W0(16), .W1(21), .WO(8)) i3 (), i4 ();
  assign {i0.ce, i0.in_valid, i0.acc_clr, i0.acc_last, i0.din0, i0.din1} = {ce, iv, clr, last, d0, d1};
  assign {i1.ce, i1.in_valid, i1.acc_clr, i1.acc_last, i1.din0, i1.din1} = {ce, iv, clr, last, d0, d1};
  assign {i2.ce, i2.in_valid, i2.acc_clr, i2.acc_last, i2.din0, i2.din1} = {ce, iv, clr, last, d0, d1};
  assign {i3.ce, i3.in_valid, i3.acc_clr, i3.acc_last, i3.din0, i3.din1} = {ce, iv, clr, last, d0, d1};
  assign {i4.ce, i4.in_valid, i4.acc_clr, i4.acc_last, i4.din0, i4.din1} = {ce, iv, clr, last, d0, d1};
  assign {i5.ce, i5.in_valid, i5.acc_clr, i5.acc_last, i5.din0, i5.din1} = {ce, iv, clr, last, d0, d1};
  myproject_mul_pipe u0 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(i0));
  myproject_mul_pipe #(.SHIFT(2)) u1 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(i1));
  myproject_mul_pipe #(.SHIFT(2), .RND(RND_HALF_UP)) u2 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(i2));
  myproject_mul_pipe #(.dout_WIDTH(8), .SAT(SAT_CLAMP)) u3 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(i3));
  myproject_mul_pipe #(.dout_WIDTH(8), .SAT(SAT_WRAP)) u4 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(i4));
  myproject_mul_pipe #(.MODE(MUL_MODE_MAC)) u5 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(i5));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge ap_clk);
  endtask
  task automatic drive(input logic v, input logic [15:0] a, input logic [20:0] b, input logic c, input logic l);
    iv = v;
    d0 = a;
    d1 = b;
    clr = c;
    last = l;
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_valid", i0.out_valid, 0);
    chk("rst_dout", i0.dout, 0);
    chk("rst_ovf", i0.ovf, 0);
    chk("rst_mac_valid", i5.out_valid, 0);
    ap_rst = 1'b0;
    drive(1, 16'hFFFD, 5, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("lat1_valid", i0.out_valid, 0);
    tick();
    chk("lat2_valid", i0.out_valid, 1);
    chk("neg_dout", $signed(i0.dout), -15);
    chk("neg_ovf", i0.ovf, 0);
    chk("neg_sh2_trunc", $signed(i1.dout), -4);
    chk("neg_sh2_round", $signed(i2.dout), -4);
    chk("neg_w8", $signed(i3.dout), -15);
    tick();
    chk("lat3_valid", i0.out_valid, 0);
    chk("hold_dout", $signed(i0.dout), -15);
    drive(1, 2, 5, 0, 0);
    tick();
    drive(1, 16'hFFFD, 5, 0, 0);
    tick();
    drive(1, 20, 10, 0, 0);
    chk("b2b1_valid", i0.out_valid, 1);
    chk("b2b1_dout", i0.dout, 10);
    chk("p10_trunc", i1.dout, 2);
    chk("p10_round", i2.dout, 3);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("b2b2_valid", i0.out_valid, 1);
    chk("b2b2_dout", $signed(i0.dout), -15);
    chk("m15_trunc", $signed(i1.dout), -4);
    chk("m15_round", $signed(i2.dout), -4);
    tick();
    chk("b2b3_valid", i0.out_valid, 1);
    chk("p200_wide", i0.dout, 200);
    chk("p200_wide_ovf", i0.ovf, 0);
    chk("sat_dout", i3.dout, 127);
    chk("sat_ovf", i3.ovf, 1);
    chk("wrap_dout", i4.dout, 'hC8);
    chk("wrap_ovf", i4.ovf, 1);
    chk("mul_no_mac_out", i5.out_valid, 0);
    tick();
    chk("sat_idle_valid", i3.out_valid, 0);
    chk("sat_hold_dout", i3.dout, 127);
    chk("sat_hold_ovf", i3.ovf, 1);
    drive(1, 3, 4, 0, 0);
    tick();
    drive(1, 5, 6, 0, 0);
    tick();
    ce = 1'b0;
    drive(1, 100, 100, 1, 1);
    chk("pre_stall_dout", i0.dout, 12);
    repeat (3) begin
      tick();
      chk("stall_valid", i0.out_valid, 1);
      chk("stall_dout", i0.dout, 12);
    end
    ce = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    chk("post_stall_valid", i0.out_valid, 1);
    chk("post_stall_dout", i0.dout, 30);
    tick();
    chk("post_stall_idle", i0.out_valid, 0);
    drive(1, 2, 3, 1, 0);
    tick();
    drive(1, 4, 5, 0, 0);
    tick();
    drive(1, 16'hFFFF, 6, 0, 1);
    tick();
    drive(1, 7, 1, 1, 1);
    chk("mac_beat1_quiet", i5.out_valid, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("mac_beat2_quiet", i5.out_valid, 0);
    tick();
    chk("mac_sum1_valid", i5.out_valid, 1);
    chk("mac_sum1_dout", i5.dout, 20);
    tick();
    chk("mac_sum2_valid", i5.out_valid, 1);
    chk("mac_sum2_dout", i5.dout, 7);
    tick();
    chk("mac_idle", i5.out_valid, 0);
    drive(1, 9, 9, 1, 0);
    tick();
    drive(1, 9, 9, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    chk("mid_rst_valid", i5.out_valid, 0);
    chk("mid_rst_dout", i5.dout, 0);
    chk("mid_rst_mul_dout", i0.dout, 0);
    repeat (2) begin
      tick();
      chk("flushed_valid", i5.out_valid, 0);
    end
    drive(1, 1, 2, 1, 0);
    tick();
    drive(1, 3, 4, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    chk("resum_quiet", i5.out_valid, 0);
    tick();
    chk("resum_valid", i5.out_valid, 1);
    chk("resum_dout", i5.dout, 14);
    tick();
    chk("resum_idle", i5.out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
